mac_datapath: RTL and testbench

Datapath and operand store for the multiply-accumulate chip: the other end of the MAC controller's load/count interface. It holds a host-written buffer of operand pairs. It executes the `ld_a`/`ld_b`/`ld_m`/`ld_acc`/`ld_out`/`count_enb`/`count_reset` strobes issued by the controller FSM. It returns `CMP`, which tells the controller whether more terms remain. The final dot product is presented on `result` with a one-cycle `result_valid` pulse.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_operand_ram.sv | 34 +++
 rtl/mac_datapath.sv | 110 +++++++++++
 tb/tb_mac_datapath.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the MAC chip: default datapath sizes and the controller
// state encoding, so the controller and the datapath agree on one definition.
package mac_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_DEPTH  = 16;
  localparam int MAC_ADDR_W = $clog2(MAC_DEPTH);
  localparam int MAC_ACC_W  = 2 * MAC_DATA_W + MAC_ADDR_W;

  typedef enum logic [2:0] {
    CTL_IDLE    = 3'd0,
    CTL_CLEAR   = 3'd1,
    CTL_LD_AB   = 3'd2,
    CTL_WAIT_AB = 3'd3,
    CTL_LD_M    = 3'd4,
    CTL_WAIT_M  = 3'd5,
    CTL_LD_ACC  = 3'd6,
    CTL_DECIDE  = 3'd7
  } ctl_state_t;

endpackage

// File: rtl/mac_operand_ram.sv
// Operand-pair register file: one synchronous write port, one asynchronous read
// port, so a same-edge write is seen by the reader only on the following cycle.
module mac_operand_ram
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int DEPTH  = MAC_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_a,
  input  logic [DATA_W-1:0] i_wr_b,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b
);

  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [2*DATA_W-1:0] w_word;

  // Contents are deliberately not reset; the host initialises the buffer.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= {i_wr_a, i_wr_b};
    end
  end

  assign w_word = r_mem[i_rd_addr];
  assign o_rd_a = w_word[2*DATA_W-1:DATA_W];
  assign o_rd_b = w_word[DATA_W-1:0];

endmodule

// File: rtl/mac_datapath.sv
// MAC datapath: operand buffer, A/B/M/ACC/result registers, term counter and the
// CMP "terms remain" flag returned to the controller.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int DEPTH  = MAC_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ACC_W  = 2 * DATA_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic [ADDR_W:0]   len,
  input  logic              ld_a,
  input  logic              ld_b,
  input  logic              ld_m,
  input  logic              ld_acc,
  input  logic              ld_out,
  input  logic              count_enb,
  input  logic              count_reset,
  output logic              CMP,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_eff_len;
  logic [DATA_W-1:0]   r_a, r_b;
  logic [DATA_W-1:0]   w_rd_a, w_rd_b;
  logic [2*DATA_W-1:0] r_m;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_result;
  logic                r_valid;

  mac_operand_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_a    (wr_a),
    .i_wr_b    (wr_b),
    .i_rd_addr (r_cnt[ADDR_W-1:0]),
    .o_rd_a    (w_rd_a),
    .o_rd_b    (w_rd_b)
  );

  // A zero-length job still runs one term; oversize jobs stop at the buffer size.
  always_comb begin
    w_eff_len = len;
    if (len == '0) begin
      w_eff_len = ONE_C;
    end else if (len > DEPTH_C) begin
      w_eff_len = DEPTH_C;
    end
  end

  assign CMP = (r_cnt < w_eff_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (ld_a) begin
        r_a <= w_rd_a;
      end
      if (ld_b) begin
        r_b <= w_rd_b;
      end
      if (ld_m) begin
        r_m <= {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};
      end
      // The result sees ACC as it was before any same-edge clear.
      if (ld_out) begin
        r_result <= r_acc;
      end
      r_valid <= ld_out;
      if (count_reset) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        if (ld_acc) begin
          r_acc <= r_acc + {{(ACC_W - 2*DATA_W){1'b0}}, r_m};
        end
        if (count_enb && (r_cnt < DEPTH_C)) begin
          r_cnt <= r_cnt + ONE_C;
        end
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_mac_datapath.sv
// Self-checking bench for mac_datapath: table-driven jobs, hand-written corner
// sequences and randomized jobs checked against a dot-product reference model.
module tb_mac_datapath;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int ACC_W  = 2 * DATA_W + ADDR_W;

  localparam bit [6:0] S_AB  = 7'b1100000;
  localparam bit [6:0] S_M   = 7'b0010000;
  localparam bit [6:0] S_ACC = 7'b0001000;
  localparam bit [6:0] S_OUT = 7'b0000100;
  localparam bit [6:0] S_ENB = 7'b0000010;
  localparam bit [6:0] S_CLR = 7'b0000001;
  localparam bit [6:0] S_NOP = 7'b0000000;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_a, wr_b;
  logic [ADDR_W:0]   len;
  logic              ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb, count_reset;
  logic              CMP;
  logic [ACC_W-1:0]  result;
  logic              result_valid;

  mac_datapath dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_a         (wr_a),
    .wr_b         (wr_b),
    .len          (len),
    .ld_a         (ld_a),
    .ld_b         (ld_b),
    .ld_m         (ld_m),
    .ld_acc       (ld_acc),
    .ld_out       (ld_out),
    .count_enb    (count_enb),
    .count_reset  (count_reset),
    .CMP          (CMP),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int len;
    int exp_terms;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  int rv_seen = 0;
  int sh_a [DEPTH];
  int sh_b [DEPTH];

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  task automatic cyc(input bit [6:0] s);
    {ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb, count_reset} = s;
    @(posedge clk);
    #1;
    {ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb, count_reset} = S_NOP;
    if (result_valid === 1'b1) rv_seen++;
  endtask

  task automatic write(input int addr, input int a, input int b);
    wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_a = DATA_W'(a); wr_b = DATA_W'(b);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    sh_a[addr] = a;
    sh_b[addr] = b;
  endtask

  // The counter is not a port; recover it by sweeping len, since CMP=0 exactly for len in 1..cnt.
  task automatic probe_cnt(output int c);
    logic [ADDR_W:0] orig;
    orig = len;
    c = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      len = (ADDR_W + 1)'(k);
      #1;
      if (CMP !== 1'b1) c++;
    end
    len = orig;
    #1;
  endtask

  function automatic longint model_sum(input int nterms);
    longint s = 0;
    for (int i = 0; i < nterms; i++) s += longint'(sh_a[i]) * longint'(sh_b[i]);
    return s;
  endfunction

  function automatic int model_terms(input int l);
    if (l < 1) return 1;
    if (l > DEPTH) return DEPTH;
    return l;
  endfunction

  task automatic run_job(input int l, output int terms, output int pulses,
                         output longint res, output int cmp_bits);
    int rv0;
    len = (ADDR_W + 1)'(l);
    cyc(S_CLR);
    rv0 = rv_seen;
    terms = 0;
    cmp_bits = 0;
    do begin
      cyc(S_AB);  cyc(S_NOP);
      cyc(S_M);   cyc(S_NOP);
      cyc(S_ACC | S_ENB); cyc(S_NOP);
      terms++;
      cmp_bits = (cmp_bits << 1) | int'(CMP === 1'b1);
    end while (CMP === 1'b1 && terms < 40);
    cyc(S_OUT);
    res = longint'(result);
    cyc(S_NOP);
    cyc(S_NOP);
    pulses = rv_seen - rv0;
  endtask

  initial begin
    vec_t   vecs [7];
    int     terms, pulses, cmp_bits, c, l, nt;
    longint res, part;

    vecs[0] = '{len: 3,  exp_terms: 3};
    vecs[1] = '{len: 0,  exp_terms: 1};
    vecs[2] = '{len: 1,  exp_terms: 1};
    vecs[3] = '{len: 16, exp_terms: 16};
    vecs[4] = '{len: 20, exp_terms: 16};
    vecs[5] = '{len: 31, exp_terms: 16};
    vecs[6] = '{len: 7,  exp_terms: 7};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0; len = '0;
    {ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb, count_reset} = S_NOP;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_result", result, 0);
    check("reset_valid", result_valid, 0);
    check("reset_cmp", CMP, 1);
    probe_cnt(c);
    check("reset_cnt", c, 0);

    // Basic dot product
    write(0, 3, 4); write(1, 5, 6); write(2, 7, 8);
    run_job(3, terms, pulses, res, cmp_bits);
    check("basic_result", res, 98);
    check("basic_cmp_seq", cmp_bits, 3'b110);
    check("basic_pulses", pulses, 1);

    // Table-driven jobs over a random buffer
    for (int i = 0; i < DEPTH; i++) write(i, $urandom_range(0, 255), $urandom_range(0, 255));
    foreach (vecs[v]) begin
      run_job(vecs[v].len, terms, pulses, res, cmp_bits);
      check($sformatf("tbl%0d_len%0d_result", v, vecs[v].len), res, model_sum(vecs[v].exp_terms));
      check($sformatf("tbl%0d_terms", v), terms, vecs[v].exp_terms);
      check($sformatf("tbl%0d_pulses", v), pulses, 1);
      probe_cnt(c);
      check($sformatf("tbl%0d_cnt", v), c, vecs[v].exp_terms);
    end

    // Max values and counter saturation
    for (int i = 0; i < DEPTH; i++) write(i, 255, 255);
    run_job(16, terms, pulses, res, cmp_bits);
    check("max_result", res, 1040400);
    probe_cnt(c);
    check("max_cnt", c, 16);
    repeat (3) cyc(S_ENB);
    probe_cnt(c);
    check("sat_cnt", c, 16);

    // ld_out + count_reset on one edge
    for (int i = 0; i < DEPTH; i++) write(i, $urandom_range(0, 255), $urandom_range(0, 255));
    len = 5'd16;
    cyc(S_CLR);
    repeat (2) begin
      cyc(S_AB); cyc(S_M); cyc(S_ACC | S_ENB);
    end
    part = model_sum(2);
    cyc(S_OUT | S_CLR);
    check("out_clr_result", result, part);
    check("out_clr_valid", result_valid, 1);
    probe_cnt(c);
    check("out_clr_cnt", c, 0);
    cyc(S_OUT);
    check("out_clr_acc", result, 0);

    // count_reset + count_enb
    repeat (3) cyc(S_ENB);
    probe_cnt(c);
    check("enb3_cnt", c, 3);
    cyc(S_ENB | S_CLR);
    probe_cnt(c);
    check("clr_enb_cnt", c, 0);

    // Write/read collision at address 0
    write(0, 2, 3);
    len = 5'd1;
    cyc(S_CLR);
    wr_en = 1'b1; wr_addr = '0; wr_a = 8'd9; wr_b = 8'd9;
    cyc(S_AB);
    wr_en = 1'b0;
    sh_a[0] = 9; sh_b[0] = 9;
    cyc(S_M); cyc(S_ACC); cyc(S_OUT);
    check("collide_old", result, 6);
    run_job(1, terms, pulses, res, cmp_bits);
    check("collide_new", res, 81);

    // Asynchronous reset in the middle of a job
    len = 5'd3;
    cyc(S_CLR);
    cyc(S_AB); cyc(S_M); cyc(S_ACC | S_ENB);
    cyc(S_AB); cyc(S_M);
    cyc(S_OUT);
    check("pre_rst_valid", result_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_cmp", CMP, 1);
    probe_cnt(c);
    check("rst_cnt", c, 0);
    rst = 1'b0;
    c = rv_seen;
    repeat (3) cyc(S_NOP);
    cyc(S_OUT);
    check("rst_acc", result, 0);
    cyc(S_ACC); cyc(S_OUT);
    check("rst_m", result, 0);
    cyc(S_M); cyc(S_ACC); cyc(S_OUT);
    check("rst_ab", result, 0);
    check("rst_no_stray_valid", rv_seen - c, 3);

    // Randomized jobs against the model
    for (int j = 0; j < 8; j++) begin
      for (int n = 0; n < 4; n++) write($urandom_range(0, DEPTH - 1), $urandom_range(0, 255), $urandom_range(0, 255));
      l = $urandom_range(0, 31);
      nt = model_terms(l);
      run_job(l, terms, pulses, res, cmp_bits);
      check($sformatf("rnd%0d_len%0d_result", j, l), res, model_sum(nt));
      check($sformatf("rnd%0d_terms", j), terms, nt);
      check($sformatf("rnd%0d_pulses", j), pulses, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
